// File: rtl/uart_rx_fifo.sv
// Receive-side FWFT byte buffer between the UART receiver and the host.
// Each entry stores {framing_error, byte}. A sticky overrun flag records dropped bytes.
module uart_rx_fifo #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              rx_clk,
    input  logic              rst_n,
    input  logic [7:0]        wr_data,
    input  logic              wr_en,
    input  logic              wr_err,
    output logic [7:0]        rd_data,
    output logic              rd_err,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              overrun,
    input  logic              clr_overrun
);

    localparam logic [ADDR_W:0] LP_FULL_CNT = (ADDR_W + 1)'(DEPTH);

    logic [8:0]        r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_overrun;

    logic              w_full;
    logic              w_empty;
    logic              w_rd_fire;
    logic              w_wr_fire;
    logic              w_drop;
    logic [8:0]        w_head;

    assign w_full    = (r_count == LP_FULL_CNT);
    assign w_empty   = (r_count == '0);
    assign w_rd_fire = !w_empty && rd_ready;
    // A read in the same cycle frees the slot, so a full FIFO can still accept.
    assign w_wr_fire = wr_en && (!w_full || w_rd_fire);
    assign w_drop    = wr_en && w_full && !w_rd_fire;

    always_ff @(posedge rx_clk) begin
        if (w_wr_fire) begin
            r_mem[r_wr_ptr] <= {wr_err, wr_data};
        end
    end

    always_ff @(posedge rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_fire) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_fire) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (w_wr_fire && !w_rd_fire) begin
            r_count <= r_count + 1'b1;
        end else if (w_rd_fire && !w_wr_fire) begin
            r_count <= r_count - 1'b1;
        end
    end

    // Set has priority over clear so a drop is never lost.
    always_ff @(posedge rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end else if (clr_overrun) begin
            r_overrun <= 1'b0;
        end
    end

    // Storage is not reset, so gate the head to keep outputs at zero while empty.
    assign w_head   = w_empty ? 9'h000 : r_mem[r_rd_ptr];
    assign rd_data  = w_head[7:0];
    assign rd_err   = w_head[8];
    assign rd_valid = !w_empty;
    assign count    = r_count;
    assign full     = w_full;
    assign empty    = w_empty;
    assign overrun  = r_overrun;

endmodule
